// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction memory with programmable response latency and flush.
// Define IMEM_ALIGN_CHECK_EN to return a NOP with resp_err for odd (misaligned) fetch addresses.
module imem_responder #(
  parameter int AW = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [15:0]   req_addr,
  output logic          req_ready,
  input  logic          flush,
  output logic          resp_valid,
  output logic [15:0]   resp_instr,
  output logic [15:0]   resp_addr,
  output logic          resp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [15:0]   fetch_word;
  logic [AW-1:0] widx;
  logic          accept;
  logic          unused_bits;
  assign widx        = req_addr[AW:1];
  assign unused_bits = ^{req_addr[15:AW+1], req_addr[0]};
  assign req_ready   = (state == IDLE) | (cnt == 4'd0);
  assign accept      = req_valid & req_ready & ~flush;
  assign resp_valid  = (state == BUSY) & (cnt == 4'd0) & ~flush;
  // Array has no reset; the read at accept sees the pre-load word (read-before-write).
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
`ifdef IMEM_ALIGN_CHECK_EN
  assign fetch_word = req_addr[0] ? 16'h0800 : mem[widx];
  always_ff @(posedge clk or negedge rst)
    if (!rst) resp_err <= 1'b0;
    else if (accept) resp_err <= req_addr[0];
`else
  assign fetch_word = mem[widx];
  assign resp_err   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_instr <= 16'h0000;
      resp_addr  <= 16'h0000;
    end else if (accept) begin
      state      <= BUSY;
      cnt        <= 4'(LATENCY - 1);
      resp_instr <= fetch_word;
      resp_addr  <= req_addr;
    end else if (state == BUSY) begin
      if (flush || cnt == 4'd0) state <= IDLE;
      else cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of three responder instances (LATENCY 1, 2, 3) sharing one stimulus.
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush, load_en;
  logic [15:0] req_addr, load_data;
  logic [9:0]  load_addr;
  logic [3:1]  ready, valid, err;
  logic [15:0] instr [3:1];
  logic [15:0] addr [3:1];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  imem_responder #(.AW(10), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[1]), .flush(flush), .resp_valid(valid[1]), .resp_instr(instr[1]), .resp_addr(addr[1]),
    .resp_err(err[1]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  imem_responder #(.AW(10), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[2]), .flush(flush), .resp_valid(valid[2]), .resp_instr(instr[2]), .resp_addr(addr[2]),
    .resp_err(err[2]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  imem_responder #(.AW(10), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready[3]), .flush(flush), .resp_valid(valid[3]), .resp_instr(instr[3]), .resp_addr(addr[3]),
    .resp_err(err[3]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    nxt();
    load_en = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; flush = 1'b0;
    load_en = 1'b0; load_addr = 10'h0; load_data = 16'h0;
    #2 rst = 1'b0;
    #1;
    chk("reset resp_valid", 16'(valid[2]), 16'h0);
    chk("reset resp_instr", instr[2], 16'h0);
    chk("reset resp_addr", addr[2], 16'h0);
    chk("reset resp_err", 16'(err[2]), 16'h0);
    chk("reset req_ready", 16'(ready[2]), 16'h1);
    nxt();
    rst = 1'b1;
    load(10'd0, 16'h1111);
    load(10'd1, 16'h2222);
    load(10'd2, 16'h3333);
    load(10'd3, 16'hA5C3);
    load(10'd8, 16'hBEEF);
    load(10'd16, 16'h5A5A);
    load(10'd1023, 16'h7E7E);
    idle(1);
    // LATENCY=2 basic fetch
    req_valid = 1'b1; req_addr = 16'h0006;
    @(negedge clk);
    chk("l2 ready at accept", 16'(ready[2]), 16'h1);
    chk("l2 no early valid", 16'(valid[2]), 16'h0);
    nxt();
    req_valid = 1'b0;
    @(negedge clk);
    chk("l2 valid t+1", 16'(valid[2]), 16'h0);
    chk("l2 ready t+1", 16'(ready[2]), 16'h0);
    nxt();
    @(negedge clk);
    chk("l2 valid t+2", 16'(valid[2]), 16'h1);
    chk("l2 instr", instr[2], 16'hA5C3);
    chk("l2 addr", addr[2], 16'h0006);
    nxt();
    @(negedge clk);
    chk("l2 valid t+3", 16'(valid[2]), 16'h0);
    chk("l2 ready t+3", 16'(ready[2]), 16'h1);
    idle(4);
    // LATENCY=1 back-to-back
    req_valid = 1'b1; req_addr = 16'h0000;
    @(negedge clk);
    chk("l1 ready 0", 16'(ready[1]), 16'h1);
    nxt();
    req_addr = 16'h0002;
    @(negedge clk);
    chk("l1 valid 0", 16'(valid[1]), 16'h1);
    chk("l1 instr 0", instr[1], 16'h1111);
    chk("l1 ready 1", 16'(ready[1]), 16'h1);
    nxt();
    req_addr = 16'h0004;
    @(negedge clk);
    chk("l1 valid 1", 16'(valid[1]), 16'h1);
    chk("l1 instr 1", instr[1], 16'h2222);
    chk("l1 ready 2", 16'(ready[1]), 16'h1);
    nxt();
    req_addr = 16'hFFFE;
    @(negedge clk);
    chk("l1 valid 2", 16'(valid[1]), 16'h1);
    chk("l1 instr 2", instr[1], 16'h3333);
    nxt();
    req_valid = 1'b0;
    @(negedge clk);
    chk("wrap valid", 16'(valid[1]), 16'h1);
    chk("wrap instr", instr[1], 16'h7E7E);
    chk("wrap addr", addr[1], 16'hFFFE);
    nxt();
    @(negedge clk);
    chk("l1 valid idle", 16'(valid[1]), 16'h0);
    idle(4);
    // LATENCY=3 flush then redirect
    req_valid = 1'b1; req_addr = 16'h0010;
    nxt();
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("l3 flush valid", 16'(valid[3]), 16'h0);
    nxt();
    flush = 1'b0; req_valid = 1'b1; req_addr = 16'h0020;
    @(negedge clk);
    chk("l3 idle after flush", 16'(ready[3]), 16'h1);
    chk("l3 no stale resp", 16'(valid[3]), 16'h0);
    nxt();
    req_valid = 1'b0;
    @(negedge clk);
    chk("l3 redirect t+1", 16'(valid[3]), 16'h0);
    nxt();
    @(negedge clk);
    chk("l3 redirect t+2", 16'(valid[3]), 16'h0);
    nxt();
    @(negedge clk);
    chk("l3 redirect valid", 16'(valid[3]), 16'h1);
    chk("l3 redirect instr", instr[3], 16'h5A5A);
    chk("l3 redirect addr", addr[3], 16'h0020);
    idle(4);
    // load and accept to the same word on one edge
    req_valid = 1'b1; req_addr = 16'h0010;
    load_en = 1'b1; load_addr = 10'd8; load_data = 16'h1234;
    nxt();
    req_valid = 1'b0; load_en = 1'b0;
    nxt();
    @(negedge clk);
    chk("rbw valid", 16'(valid[2]), 16'h1);
    chk("rbw old word", instr[2], 16'hBEEF);
    idle(3);
    req_valid = 1'b1; req_addr = 16'h0010;
    nxt();
    req_valid = 1'b0;
    nxt();
    @(negedge clk);
    chk("rbw new valid", 16'(valid[2]), 16'h1);
    chk("rbw new word", instr[2], 16'h1234);
    idle(4);
    // reset while busy
    req_valid = 1'b1; req_addr = 16'h0006;
    nxt();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid rst valid", 16'(valid[3]), 16'h0);
    chk("mid rst instr", instr[3], 16'h0);
    chk("mid rst ready", 16'(ready[3]), 16'h1);
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no resp after rst", 16'(valid[3]), 16'h0);
      nxt();
    end
    // odd address
    req_valid = 1'b1; req_addr = 16'h0003;
    nxt();
    req_valid = 1'b0;
    nxt();
    @(negedge clk);
    chk("odd valid", 16'(valid[2]), 16'h1);
    chk("odd addr", addr[2], 16'h0003);
`ifdef IMEM_ALIGN_CHECK_EN
    chk("odd err", 16'(err[2]), 16'h1);
    chk("odd instr", instr[2], 16'h0800);
`else
    chk("odd err", 16'(err[2]), 16'h0);
    chk("odd instr", instr[2], 16'h2222);
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
